// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, ALU ops, states, error codes.
package mc_pkg;

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAddi  = 4'b0001;
    localparam logic [3:0] OpLw    = 4'b0010;
    localparam logic [3:0] OpSw    = 4'b0011;
    localparam logic [3:0] OpBeq   = 4'b0100;
    localparam logic [3:0] OpJ     = 4'b0101;
    localparam logic [3:0] OpHalt  = 4'b1111;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrIllegal = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StErr
    } state_e;

    // HALT is decoded separately, so it is not part of the executable set.
    function automatic logic op_legal(input logic [3:0] op);
        return (op == OpRtype) || (op == OpAddi) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpJ);
    endfunction

    function automatic logic [2:0] alu_op(input logic [3:0] op, input logic [2:0] funct);
        logic [2:0] res;
        res = AluAnd;
        if (op == OpRtype) begin
            res = funct;
        end else if ((op == OpAddi) || (op == OpLw) || (op == OpSw)) begin
            res = AluAdd;
        end else if (op == OpBeq) begin
            res = AluSub;
        end
        return res;
    endfunction

endpackage

// File: rtl/mc_ctrl_mem_wait_timer.sv
// Counts cycles a memory access has been waiting; flags when the limit is reached.
module mem_wait_timer #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [7:0] cnt_q, cnt_d;

    assign timeout_o = (cnt_q == 8'(Timeout));

    // Next count: clear wins, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !timeout_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle sequencer: fetch/decode/exec/mem/writeback with memory handshake and timeout.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             pc_en,
    output logic             ir_en,
    output logic             memtoreg,
    output logic             alusrc,
    output logic             regdst,
    output logic             regwrite,
    output logic             jump,
    output logic             pcsrc,
    output logic [2:0]       alucontrol,
    output logic             halted,
    output logic [1:0]       error,
    output logic [CNT_W-1:0] instr_count
);

    state_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic [1:0]         error_q, error_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               retire;
    logic               wait_clr;
    logic               timeout;

    logic [3:0] op;
    logic [2:0] funct;
    logic       unused_instr;

    assign op           = instr[15:12];
    assign funct        = instr[5:3];
    assign unused_instr = ^{instr[11:6], instr[2:0]};

    // Counter restarts on each new state and on each accepted ack.
    assign wait_clr = (state_d != state_q) || (mem_req && mem_ack);

    mem_wait_timer #(
        .Timeout(MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clr_i    (wait_clr),
        .en_i     (mem_req),
        .timeout_o(timeout)
    );

    // Next-state and Moore outputs; ack-dependent strobes are the only Mealy terms.
    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        error_d    = error_q;
        count_d    = count_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        jump       = 1'b0;
        alucontrol = AluAnd;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    error_d = ErrTimeout;
                    state_d = StErr;
                end
            end
            StDecode: begin
                if (op == OpHalt) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else if (!op_legal(op)) begin
                    error_d = ErrIllegal;
                    state_d = StErr;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alucontrol = alu_op(op, funct);
                alusrc     = (op == OpAddi) || (op == OpLw) || (op == OpSw);
                case (op)
                    OpJ: begin
                        jump   = 1'b1;
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end
                    OpBeq: begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end
                    OpRtype, OpAddi: state_d = StWb;
                    OpLw, OpSw:      state_d = StMem;
                    default:         state_d = StErr;
                endcase
            end
            StMem: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_we     = (op == OpSw);
                alusrc     = 1'b1;
                alucontrol = alu_op(op, funct);
                if (mem_ack) begin
                    if (op == OpSw) begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    error_d = ErrTimeout;
                    state_d = StErr;
                end
            end
            StWb: begin
                regwrite   = 1'b1;
                pc_en      = 1'b1;
                retire     = 1'b1;
                alucontrol = alu_op(op, funct);
                regdst     = (op == OpRtype);
                alusrc     = (op == OpAddi);
                memtoreg   = (op == OpLw);
            end
            StHalt, StErr: begin
                state_d = state_q;
            end
        endcase

        if (retire) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = run ? StFetch : StIdle;
        end
    end

    assign pcsrc       = (state_q == StExec) && (op == OpBeq) && zero;
    assign halted      = halted_q;
    assign error       = error_q;
    assign instr_count = count_q;

    // State and sticky status registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            halted_q <= 1'b0;
            error_q  <= ErrNone;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle sequencer for the 16-bit-instruction / 8-bit-data datapath.
- Drives datapath control lines (memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol) and PC/IR enables, one instruction at a time.
- Performs a req/ack handshake with shared instruction/data memory; flags halt, illegal opcode and memory timeout.
- Sits between top level and datapath; replaces a single-cycle decoder.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for mem_ack per access before error (1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- run  in  1  1 = free-run; 0 = stop in IDLE after current instruction
- instr  in  16  IR contents from datapath (opcode [15:12], funct [5:3])
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory access complete this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  0 = address from pc, 1 = from aluout
- pc_en  out  1  load pcnext into PC this cycle
- ir_en  out  1  load readdata into IR this cycle
- memtoreg, alusrc, regdst, regwrite, jump, pcsrc  out  1 each  datapath controls
- alucontrol  out  3  ALU op
- halted  out  1  sticky, HALT executed
- error  out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout
- instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, wait counter 0, instr_count 0, halted 0, error 00. All control outputs are 0. Reset mid-access drops mem_req on the next cycle.
- Opcodes: 0000 RTYPE, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 1111 HALT; all others illegal.
- alucontrol: RTYPE = funct; ADDI/LW/SW = 010 (add); BEQ = 110 (sub); 000 otherwise.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- Outputs are Moore, decoded from state plus registered instr. Exception: pcsrc = (state==EXEC && op==BEQ && zero), combinational.
- IDLE: no outputs. Go to FETCH when run=1.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - On mem_ack: ir_en=1 that cycle, go to DECODE.
  - Otherwise increment wait counter. If the counter equals MEM_TIMEOUT and no ack: error=10, go to ERR.
  - Wait counter clears on every ack and every state entry.
- DECODE: one cycle.
  - HALT: go to HALT, set halted.
  - Illegal: error=01, go to ERR.
  - Otherwise go to EXEC.
- EXEC: ADDI/LW/SW set alusrc=1.
  - J: jump=1, pc_en=1, retire.
  - BEQ: pc_en=1, retire (pcsrc selects target).
  - RTYPE/ADDI: go to WB.
  - LW/SW: go to MEM.
- MEM: mem_req=1, iord=1, mem_we=(op==SW), alusrc=1. Same ack/timeout rules as FETCH.
  - On ack: LW goes to WB; SW sets pc_en=1 and retires.
- WB: regwrite=1, pc_en=1, retire.
  - RTYPE: regdst=1.
  - ADDI: regdst=0, alusrc=1.
  - LW: regdst=0, memtoreg=1.
- Retire: instr_count += 1 (mod 2^CNT_W). Next state is FETCH if run=1, else IDLE.
- HALT and ERR: absorbing, all controls 0, leave only by reset.
- pc_en, ir_en and regwrite are each exactly one-cycle pulses per instruction.
- Latency with zero-wait memory: J/BEQ 3 cycles, RTYPE/ADDI/SW 4, LW 5.
- mem_ack while mem_req=0 is ignored.
- mem_ack on the same cycle the counter reaches MEM_TIMEOUT counts as success.

Decomposition:
- Shared package mc_pkg: opcode localparams, ALU op codes (ADD=010, SUB=110, AND=000, OR=001, SLT=111), state encoding, error codes.
- Sub-module mem_wait_timer: wait counter with clear/enable and a timeout flag. Instantiated once; used in FETCH and MEM.

Test Plan:
- reset=0 for 2 cycles, then reset=1, run=1; memory returns RTYPE 0x0010 with immediate ack -> FETCH, DECODE, EXEC, WB; regwrite=1, regdst=1, alucontrol=010 in WB; instr_count=1 after 4 cycles.
- LW 0x2085, ack delayed 3 cycles in MEM -> mem_req held 4 cycles, iord=1, mem_we=0; WB has memtoreg=1; total 8 cycles.
- BEQ 0x4003 with zero=1, then with zero=0 -> pcsrc=1 vs 0 in EXEC; pc_en pulses once; 3 cycles each.
- MEM_TIMEOUT=4, mem_ack never asserted in FETCH -> error=10 and state ERR after 4 wait cycles; outputs stay 0 until reset=0.
- Opcode 0x7000 -> error=01; opcode 0xF000 -> halted=1, no pc_en; instr_count unchanged.
- run=0 during SW 0x3040 MEM wait -> SW completes (mem_we=1, pc_en pulse), then IDLE with no new mem_req.
